td4_seq_decoder: RTL and testbench
==================================

Name: td4_seq_decoder

Overview:
- Sequenced instruction decoder/control unit for the TD4 core; successor to the purely combinational decoder.
- Runs a FETCH/DECODE/EXEC cycle against an instruction memory with a valid handshake and variable latency.
- Keeps a registered carry flag and adds JC, HLT and NOP opcodes, a run/pause input and a fetch timeout fault.
- Drives the register-file load strobes, the ALU source-mux selects, the PC increment and the immediate to the datapath.

Parameters:
- DATA_W, 4, width of the immediate field and IMM output.
- TIMEOUT, 15, maximum cycles spent in FETCH waiting for INSTR_VALID before a fault is raised (1..2^TMO_W-1).
- TMO_W, 4, width of the fetch-wait counter.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- RUN  in  1  1 = sequencer may leave IDLE; 0 = pause at the next instruction boundary
- FETCH_REQ  out  1  request to instruction memory, held high while in FETCH
- INSTR_VALID  in  1  memory has OP_CODE/IMM_IN valid this cycle
- OP_CODE  in  4  opcode field
- IMM_IN  in  DATA_W  immediate field
- C_IN  in  1  ALU carry-out for the instruction in EXEC
- LOAD  out  4  one-hot load strobe: [0]=A, [1]=B, [2]=OUT, [3]=PC
- SEL_A  out  1  ALU source mux select, low bit
- SEL_B  out  1  ALU source mux select, high bit
- PC_INC  out  1  increment PC this cycle
- IMM  out  DATA_W  registered immediate
- C_FLAG  out  1  registered carry flag
- HALTED  out  1  HALT state reached
- FAULT  out  1  fetch timeout occurred

Behaviour:
- Fixed decisions: one clock, CLK. RESET is synchronous and active-high.
- Reset values: state=IDLE; LOAD=0; SEL_A=0; SEL_B=0; PC_INC=0; FETCH_REQ=0; IMM=0; C_FLAG=0; HALTED=0; FAULT=0; wait counter=0.
- RESET overrides everything, including mid-fetch, HALT and FAULT.
- IDLE: if RUN=1, go to FETCH next cycle; otherwise stay.
- FETCH:
  - FETCH_REQ=1.
  - On INSTR_VALID=1, capture OP_CODE into the opcode register and IMM_IN into IMM, then go to DECODE.
  - Otherwise the counter increments. When the counter equals TIMEOUT with INSTR_VALID still 0, go to FAULT.
  - INSTR_VALID in the same cycle as the TIMEOUT-th count wins; the instruction is taken.
  - The counter clears on leaving FETCH.
- DECODE: register SEL_A/SEL_B from the latched opcode, then go to EXEC. Select values:
  - SEL_A = op[0] | op[3]
  - SEL_B = op[1]
  - Mux meaning: 00=A, 01=B, 10=IN, 11=zero.
  - Selects hold their value through EXEC and until the next DECODE.
- EXEC (exactly one cycle):
  - LOAD[0] for op[3:2]=00.
  - LOAD[1] for op[3:2]=01.
  - LOAD[2] for 1001 and 1011.
  - LOAD[3] for 1111 (JMP), for 1110 (JNC) when C_FLAG=0, and for 1100 (JC) when C_FLAG=1.
  - PC_INC=1 exactly when LOAD[3]=0 and the opcode is not HLT.
  - C_FLAG <= C_IN for every EXEC except HLT. Jump conditions use the C_FLAG value from before this update.
  - LOAD is zero outside EXEC.
- Next state after EXEC: IDLE if RUN=0, otherwise FETCH. One instruction therefore takes 3 cycles plus memory wait.
- Opcode 1000 (HLT): no LOAD, no PC_INC; go to HALT. HALTED=1 and the unit stays there until RESET.
- Opcodes 1010 and 1101 (NOP): no LOAD, PC_INC=1, C_FLAG updated.
- FAULT state: FAULT=1, FETCH_REQ=0, all strobes 0; the unit stays there until RESET.
- RUN deasserted mid-instruction does not abort; the current instruction completes.
- State encoding is binary and is set in the package.

Decomposition:
- Package td4_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC, HALT, FAULT)
  - opcode constants (OP_ADD_A_IM … OP_JMP, OP_HLT, OP_JC, OP_NOP0/1)
  - LOAD bit indices (LD_A, LD_B, LD_OUT, LD_PC)
  - SEL encodings
- One sub-module, td4_op_decode: the combinational opcode plus carry to LOAD/SEL/PC_INC table, reused by the EXEC stage.

Test Plan:
- Reset, then RUN=1 with INSTR_VALID tied high and OP_CODE=0000, IMM_IN=5 → FETCH_REQ at cycle 1, LOAD=0001 on cycle 3, IMM=5, SEL=00, PC_INC=1.
- JNC check: C_IN=1 on an ADD so C_FLAG=1, then OP_CODE=1110 → LOAD=0000 and PC_INC=1. With C_FLAG=0, 1110 → LOAD=1000 and PC_INC=0. Repeat for 1100 (JC) with the inverse result.
- Sweep opcodes 0000–1111 with C_FLAG=0 → LOAD, SEL_B:SEL_A and PC_INC match the decode table; 1000 gives HALTED=1 and no further FETCH_REQ until RESET.
- INSTR_VALID delayed 14 cycles → instruction accepted, no FAULT. Delayed past 15 cycles → FAULT=1 with all strobes 0. RESET → IDLE with FAULT=0.
- RUN dropped during DECODE → EXEC still fires LOAD, then the unit sits in IDLE with FETCH_REQ=0. RUN=1 → FETCH next cycle.
- RESET asserted in the middle of FETCH and in the middle of EXEC → all outputs at reset values on the next edge, C_FLAG=0.

Source files
------------

// File: rtl/td4_pkg.sv
// TD4 sequencer shared definitions: states, opcodes,
// load strobe bit positions and ALU source select codes.
package td4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_HLT      = 4'b1000;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_NOP0     = 4'b1010;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JC       = 4'b1100;
  localparam logic [3:0] OP_NOP1     = 4'b1101;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  // {SEL_B, SEL_A}
  localparam logic [1:0] SEL_SRC_A    = 2'b00;
  localparam logic [1:0] SEL_SRC_B    = 2'b01;
  localparam logic [1:0] SEL_SRC_IN   = 2'b10;
  localparam logic [1:0] SEL_SRC_ZERO = 2'b11;

endpackage

// File: rtl/td4_seq_decoder_op_decode.sv
// Combinational opcode + carry flag to load strobes,
// ALU source selects and PC increment.
module td4_op_decode
  import td4_pkg::*;
(
  input  logic [3:0] op,
  input  logic       c_flag,
  output logic [3:0] load,
  output logic       sel_a,
  output logic       sel_b,
  output logic       pc_inc,
  output logic       halt
);

  always_comb begin
    load = '0;
    halt = 1'b0;
    unique case (1'b1)
      op[3:2] == 2'b00: load[LD_A] = 1'b1;
      op[3:2] == 2'b01: load[LD_B] = 1'b1;
      op == OP_OUT_B,
      op == OP_OUT_IM:  load[LD_OUT] = 1'b1;
      op == OP_JMP:     load[LD_PC] = 1'b1;
      op == OP_JNC:     load[LD_PC] = ~c_flag;
      op == OP_JC:      load[LD_PC] = c_flag;
      op == OP_HLT:     halt = 1'b1;
      default:          ;
    endcase
  end

  assign sel_a  = op[0] | op[3];
  assign sel_b  = op[1];
  assign pc_inc = ~load[LD_PC] & ~halt;

endmodule

// File: rtl/td4_seq_decoder.sv
// TD4 sequenced control unit: FETCH/DECODE/EXEC against a
// variable-latency instruction memory, carry flag, HLT and fetch timeout.
module td4_seq_decoder
  import td4_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 15,
  parameter int TMO_W   = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RUN,
  output logic              FETCH_REQ,
  input  logic              INSTR_VALID,
  input  logic [3:0]        OP_CODE,
  input  logic [DATA_W-1:0] IMM_IN,
  input  logic              C_IN,
  output logic [3:0]        LOAD,
  output logic              SEL_A,
  output logic              SEL_B,
  output logic              PC_INC,
  output logic [DATA_W-1:0] IMM,
  output logic              C_FLAG,
  output logic              HALTED,
  output logic              FAULT
);

  state_t           state;
  state_t           state_n;
  logic [3:0]       op_q;
  logic [TMO_W-1:0] cnt;
  logic [3:0]       dec_load;
  logic             dec_sel_a;
  logic             dec_sel_b;
  logic             dec_pc_inc;
  logic             dec_halt;
  logic             tmo;

  td4_op_decode u_dec (
    .op     (op_q),
    .c_flag (C_FLAG),
    .load   (dec_load),
    .sel_a  (dec_sel_a),
    .sel_b  (dec_sel_b),
    .pc_inc (dec_pc_inc),
    .halt   (dec_halt)
  );

  assign tmo = (cnt == TMO_W'(TIMEOUT));

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (RUN) state_n = ST_FETCH;
      ST_FETCH: begin
        if (INSTR_VALID) state_n = ST_DECODE;
        else if (tmo)    state_n = ST_FAULT;
      end
      ST_DECODE: state_n = ST_EXEC;
      ST_EXEC: begin
        if (dec_halt) state_n = ST_HALT;
        else if (RUN) state_n = ST_FETCH;
        else          state_n = ST_IDLE;
      end
      ST_HALT:   state_n = ST_HALT;
      ST_FAULT:  state_n = ST_FAULT;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      cnt    <= '0;
      IMM    <= '0;
      SEL_A  <= 1'b0;
      SEL_B  <= 1'b0;
      C_FLAG <= 1'b0;
    end else begin
      state <= state_n;
      // wait counter only runs while we stay in FETCH
      if (state == ST_FETCH && state_n == ST_FETCH)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if (state == ST_FETCH && INSTR_VALID) begin
        op_q <= OP_CODE;
        IMM  <= IMM_IN;
      end
      if (state == ST_DECODE) begin
        SEL_A <= dec_sel_a;
        SEL_B <= dec_sel_b;
      end
      if (state == ST_EXEC && !dec_halt)
        C_FLAG <= C_IN;
    end
  end

  assign FETCH_REQ = (state == ST_FETCH);
  assign LOAD      = (state == ST_EXEC) ? dec_load : 4'b0000;
  assign PC_INC    = (state == ST_EXEC) & dec_pc_inc;
  assign HALTED    = (state == ST_HALT);
  assign FAULT     = (state == ST_FAULT);

endmodule

// File: tb/tb_td4_seq_decoder.sv
// Self-checking bench for td4_seq_decoder: instruction table
// through a scoreboard queue plus timeout/run/reset sequences.
module tb_td4_seq_decoder;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RUN = 1'b0;
  logic       FETCH_REQ;
  logic       INSTR_VALID = 1'b0;
  logic [3:0] OP_CODE = 4'h0;
  logic [3:0] IMM_IN = 4'h0;
  logic       C_IN = 1'b0;
  logic [3:0] LOAD;
  logic       SEL_A;
  logic       SEL_B;
  logic       PC_INC;
  logic [3:0] IMM;
  logic       C_FLAG;
  logic       HALTED;
  logic       FAULT;

  td4_seq_decoder #(.DATA_W(4), .TIMEOUT(15), .TMO_W(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .RUN         (RUN),
    .FETCH_REQ   (FETCH_REQ),
    .INSTR_VALID (INSTR_VALID),
    .OP_CODE     (OP_CODE),
    .IMM_IN      (IMM_IN),
    .C_IN        (C_IN),
    .LOAD        (LOAD),
    .SEL_A       (SEL_A),
    .SEL_B       (SEL_B),
    .PC_INC      (PC_INC),
    .IMM         (IMM),
    .C_FLAG      (C_FLAG),
    .HALTED      (HALTED),
    .FAULT       (FAULT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] op;
    logic [3:0] imm;
    logic       cin;
    int         delay;
    logic [3:0] load;
    logic [1:0] sel;
    logic       pc_inc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic cflag_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_load"}, LOAD, 0);
    chk({tag, "_sel"}, {SEL_B, SEL_A}, 0);
    chk({tag, "_pcinc"}, PC_INC, 0);
    chk({tag, "_freq"}, FETCH_REQ, 0);
    chk({tag, "_imm"}, IMM, 0);
    chk({tag, "_cflag"}, C_FLAG, 0);
    chk({tag, "_halted"}, HALTED, 0);
    chk({tag, "_fault"}, FAULT, 0);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [3:0] imm,
                              input logic cin, input int delay,
                              input logic [3:0] load, input logic [1:0] sel,
                              input logic pc_inc);
    vec_t v;
    v.op = op; v.imm = imm; v.cin = cin; v.delay = delay;
    v.load = load; v.sel = sel; v.pc_inc = pc_inc;
    return v;
  endfunction

  // Expects the unit in FETCH (or about to be); runs one instruction
  // through EXEC and leaves it one edge after EXEC.
  task automatic do_instr(input vec_t v, input bit drop_run);
    vec_t e;
    int   n;
    n = 0;
    while (!FETCH_REQ && n < 4) begin
      tick();
      n++;
    end
    if (!FETCH_REQ) begin
      chk("fetch_wait", FETCH_REQ, 1);
      return;
    end
    INSTR_VALID = 1'b0;
    for (int i = 0; i < v.delay; i++) tick();
    if (v.delay > 0) chk("delay_nofault", {FAULT, FETCH_REQ}, 2'b01);
    INSTR_VALID = 1'b1;
    OP_CODE = v.op;
    IMM_IN = v.imm;
    sb.push_back(v);
    tick();
    INSTR_VALID = 1'b0;
    OP_CODE = 4'hx;
    IMM_IN = 4'hx;
    C_IN = v.cin;
    if (drop_run) RUN = 1'b0;
    tick();
    e = sb.pop_front();
    chk($sformatf("load_op%b", e.op), LOAD, e.load);
    chk($sformatf("sel_op%b", e.op), {SEL_B, SEL_A}, e.sel);
    chk($sformatf("pcinc_op%b", e.op), PC_INC, e.pc_inc);
    chk($sformatf("imm_op%b", e.op), IMM, e.imm);
    tick();
    C_IN = 1'b0;
    if (e.op != 4'b1000) cflag_m = e.cin;
    chk($sformatf("cflag_op%b", e.op), C_FLAG, cflag_m);
    chk($sformatf("load_after_op%b", e.op), LOAD, 0);
  endtask

  initial begin
    int n;
    // op, imm, cin, delay, load, {sel_b,sel_a}, pc_inc
    vecs.push_back(mk(4'b0000, 4'd5, 0, 0, 4'b0001, 2'b00, 1));
    vecs.push_back(mk(4'b0000, 4'd3, 1, 14, 4'b0001, 2'b00, 1));
    vecs.push_back(mk(4'b1110, 4'd2, 1, 3, 4'b0000, 2'b11, 1));
    vecs.push_back(mk(4'b1100, 4'd4, 0, 0, 4'b1000, 2'b01, 0));
    vecs.push_back(mk(4'b1110, 4'd6, 0, 1, 4'b1000, 2'b11, 0));
    vecs.push_back(mk(4'b1100, 4'd7, 0, 0, 4'b0000, 2'b01, 1));
    vecs.push_back(mk(4'b0001, 4'd1, 0, 0, 4'b0001, 2'b01, 1));
    vecs.push_back(mk(4'b0010, 4'd2, 0, 0, 4'b0001, 2'b10, 1));
    vecs.push_back(mk(4'b0011, 4'd3, 0, 0, 4'b0001, 2'b11, 1));
    vecs.push_back(mk(4'b0100, 4'd4, 0, 0, 4'b0010, 2'b00, 1));
    vecs.push_back(mk(4'b0101, 4'd5, 0, 0, 4'b0010, 2'b01, 1));
    vecs.push_back(mk(4'b0110, 4'd6, 0, 0, 4'b0010, 2'b10, 1));
    vecs.push_back(mk(4'b0111, 4'd7, 0, 0, 4'b0010, 2'b11, 1));
    vecs.push_back(mk(4'b1001, 4'd9, 0, 0, 4'b0100, 2'b01, 1));
    vecs.push_back(mk(4'b1010, 4'hA, 0, 0, 4'b0000, 2'b11, 1));
    vecs.push_back(mk(4'b1011, 4'hB, 0, 0, 4'b0100, 2'b11, 1));
    vecs.push_back(mk(4'b1101, 4'hD, 0, 0, 4'b0000, 2'b01, 1));
    vecs.push_back(mk(4'b1111, 4'hF, 0, 0, 4'b1000, 2'b11, 0));
    vecs.push_back(mk(4'b1000, 4'h8, 1, 0, 4'b0000, 2'b01, 0));

    RESET = 1'b1;
    tick();
    tick();
    chk_reset_vals("rst");
    RESET = 1'b0;
    tick();
    chk("idle_norun", FETCH_REQ, 0);
    RUN = 1'b1;
    tick();
    chk("fetch_cycle1", FETCH_REQ, 1);

    foreach (vecs[i]) do_instr(vecs[i], 1'b0);

    chk("halted", HALTED, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_nofetch", {HALTED, FETCH_REQ}, 2'b10);
    end

    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst_halt", HALTED, 0);
    chk("rst_halt_cflag", C_FLAG, 0);
    cflag_m = 1'b0;

    // fetch timeout: never present an instruction
    INSTR_VALID = 1'b0;
    tick();
    n = 0;
    while (FETCH_REQ && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_fault", FAULT, 1);
    chk("tmo_len_ok", (n >= 15 && n <= 16), 1);
    chk("tmo_strobes", {LOAD, PC_INC, FETCH_REQ, HALTED}, 0);
    tick();
    chk("tmo_stays", FAULT, 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst_fault", FAULT, 0);
    chk("rst_fault_freq", FETCH_REQ, 0);

    // RUN dropped during DECODE: instruction completes, then IDLE
    tick();
    do_instr(mk(4'b0100, 4'd9, 0, 0, 4'b0010, 2'b00, 1), 1'b1);
    chk("run_drop_idle", FETCH_REQ, 0);
    tick();
    chk("run_drop_idle2", FETCH_REQ, 0);
    RUN = 1'b1;
    tick();
    chk("run_resume", FETCH_REQ, 1);

    // set carry, then reset in the middle of FETCH
    do_instr(mk(4'b0101, 4'd2, 1, 0, 4'b0010, 2'b01, 1), 1'b0);
    chk("pre_rst_cflag", C_FLAG, 1);
    tick();
    chk("mid_fetch", FETCH_REQ, 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_reset_vals("rst_fetch");
    cflag_m = 1'b0;

    // reset in the middle of EXEC with a carry pending
    tick();
    INSTR_VALID = 1'b1;
    OP_CODE = 4'b0011;
    IMM_IN = 4'd6;
    tick();
    INSTR_VALID = 1'b0;
    C_IN = 1'b1;
    tick();
    chk("mid_exec_load", LOAD, 4'b0001);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    C_IN = 1'b0;
    chk_reset_vals("rst_exec");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
